data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data-memory stage for the RISC-V datapath, replacing the single-cycle word memory.
//  Provides a valid/ready request/response handshake, configurable access latency and byte/half/word loads and stores.
//  Loads are sign- or zero-extended. Stores are byte-lane read-modify-write.
//  Sits between execute (address = aluout, wdata = data2) and writeback (resp_rdata).
// PARAMETERS
//  DATA_W   32   word width; 32 or 64 only
//  ADDR_W   32   byte-address width
//  DEPTH    128  words of storage; power of 2
//  LATENCY  2    edges from request accept to response edge; >= 1
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       controller can accept a request (IDLE only)
//  req_we       in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   DATA_W  store data; low-order bytes are used for sub-word stores
//  req_size     in   2       0 = byte, 1 = half, 2 = word, 3 = dword (legal only if DATA_W = 64)
//  req_unsigned in   1       load zero-extends when 1, sign-extends when 0
//  resp_valid   out  1       response present
//  resp_ready   in   1       consumer accepts response
//  resp_rdata   out  DATA_W  load result, extended and right-justified; 0 for stores
//  resp_err     out  1       access fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst = 0 at a rising edge), priority over everything:
//      state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0.
//      A pending store is dropped: no memory write at that edge.
//      Memory contents are retained across reset.
//  - Memory init (time zero only, not on reset): word i = i.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//      req_ready = (state == IDLE).
//      Accept edge = req_valid & req_ready. At the accept edge all req_* fields are captured; the latency counter loads LATENCY-1.
//      WAIT: counter decrements each edge. When it reaches 0, the next edge is the commit edge.
//      Commit edge: store writes memory, or load data is registered; state -> RESP.
//      LATENCY = 1: IDLE -> RESP directly; the commit edge is the edge after accept.
//      RESP: resp_valid = 1. Data and err are stable until resp_ready = 1 at an edge, then -> IDLE.
//      A new request can be accepted no earlier than the edge after the response handshake.
//  - Addressing: word index = addr[ADDR_W-1:OFS] mod DEPTH, with OFS = log2(DATA_W/8).
//      Upper bits are ignored, so addresses wrap.
//      Lane = addr[OFS-1:0].
//  - Load: extract 2^size bytes starting at the lane; extend to DATA_W per req_unsigned.
//  - Store: only the 2^size addressed byte lanes change; other bytes keep their old value.
//  - req_* inputs are ignored while not in IDLE.
//  - resp_ready is ignored outside RESP.
// CONFIGURATION
//  Macro DMEM_ALIGN_CHECK_EN:
//  - Defined: an access is a fault if addr is not a multiple of 2^size, or size > OFS.
//      On a fault: no memory write, resp_rdata = 0, resp_err = 1.
//      FSM timing is unchanged.
//  - Undefined: resp_err is tied 0.
//      The lane is forced down to a multiple of 2^size (low bits truncated).
//      size > OFS is treated as a full-word access.
// STRUCTURE
//  Package dmem_pkg:
//  - size codes SZ_B/SZ_H/SZ_W/SZ_D
//  - state enum (IDLE, WAIT, RESP)
//  - function size_bytes()
//  Sub-module dmem_lane_align (combinational): load extract/extend and store byte-merge, given lane, size and unsigned.
//  The top level holds the FSM, latency counter, capture registers and storage array.
// TESTING
//  Default parameters unless stated.
//  1. Load word addr 0x10, LATENCY = 2:
//     accept edge T -> commit edge T+2 -> resp_valid = 1 after T+2, resp_rdata = 0x4.
//  2. Store byte 0xAB at addr 0x21 (sb), then lw addr 0x20:
//     resp_rdata = 0x0000AB08.
//     Then lb addr 0x21, unsigned = 0 -> 0xFFFFFFAB; unsigned = 1 -> 0x000000AB.
//  3. Hold resp_ready = 0 for 5 cycles:
//     resp_valid and resp_rdata stay stable and req_ready stays 0.
//     resp_ready = 1 -> IDLE next edge, req_ready = 1.
//  4. rst = 0 at the commit edge of sw 0xDEADBEEF to addr 0x8:
//     outputs go to 0, state IDLE.
//     A following lw addr 0x8 returns 0x2 (store dropped).
//  5. Address wrap: lw addr 0x200 (word index 128 mod 128 = 0) -> resp_rdata = 0x0.
//  6. With DMEM_ALIGN_CHECK_EN: lw addr 0x6 -> resp_err = 1, resp_rdata = 0, memory unchanged.
//     Without the macro: the same lw reads word 1 -> 0x1, resp_err = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage.
//   - size codes for req_size (byte / half / word / dword)
//   - controller state encoding
//   - size_bytes(): number of bytes touched by a size code
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for one memory word.
//   word        : current contents of the addressed word
//   wdata       : store data, right-justified
//   lane        : first byte lane of the access (already legal for size)
//   size        : size code, never wider than one word
//   is_unsigned : load zero-extends when 1, sign-extends when 0
//   load_data   : extracted and extended load result
//   store_word  : word with only the addressed lanes replaced by wdata
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]              word,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [$clog2(DATA_W/8)-1:0]    lane,
  input  logic [1:0]                     size,
  input  logic                           is_unsigned,
  output logic [DATA_W-1:0]              load_data,
  output logic [DATA_W-1:0]              store_word
);

  localparam int NB = DATA_W / 8;

  logic [3:0]        nbytes;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wshift;
  logic              ext;

  assign nbytes  = 4'(size_bytes(size));
  assign shifted = word >> {lane, 3'b000};
  assign wshift  = wdata << {lane, 3'b000};

  // Fill byte for the upper part of a load: top bit of the last byte read.
  always_comb begin
    ext = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == int'(nbytes) - 1) ext = ~is_unsigned & shifted[8*b+7];
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    logic sel;
    assign sel = (gi >= int'(lane)) && (gi < int'(lane) + int'(nbytes));
    assign store_word[8*gi +: 8] = sel ? wshift[8*gi +: 8] : word[8*gi +: 8];
    assign load_data[8*gi +: 8]  = (gi < int'(nbytes)) ? shifted[8*gi +: 8] : {8{ext}};
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage with valid/ready handshake and fixed access latency.
// A request is captured in IDLE, waits LATENCY edges, commits (store write or
// load capture) and is then presented in RESP until the consumer accepts it.
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_size, req_unsigned
//   resp_valid/resp_ready, resp_rdata, resp_err
// Build option: define DMEM_ALIGN_CHECK_EN to fault misaligned or oversized
// accesses (resp_err = 1, no write). Without it, lanes are truncated down to
// the access alignment and oversized accesses become full-word accesses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int OFS   = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = OFS + IDX_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Power-up image: word i holds i. Not reloaded by reset.
  function automatic logic [DEPTH-1:0][DATA_W-1:0] mem_image();
    for (int i = 0; i < DEPTH; i++) mem_image[i] = DATA_W'(i);
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0] mem = mem_image();

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [AW-1:0]     addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;

  logic [IDX_W-1:0]  idx;
  logic [OFS-1:0]    lane_raw, lane_mask, eff_lane;
  logic [1:0]        eff_size;
  logic              fault;
  logic              commit;
  logic [DATA_W-1:0] rd_word, load_data, store_word;
  logic              unused_addr;

  // Address bits above the word index are deliberately ignored (wrap).
  assign unused_addr = ^req_addr;

  assign idx      = addr_reg[AW-1:OFS];
  assign lane_raw = addr_reg[OFS-1:0];
  assign rd_word  = mem[idx];
  assign commit   = (state_reg == WAIT) && (cnt_reg == '0);

  always_comb begin
    eff_size  = (int'(size_reg) > OFS) ? 2'(OFS) : size_reg;
    lane_mask = OFS'((1 << eff_size) - 1);
    eff_lane  = lane_raw & ~lane_mask;
    fault     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    fault     = (int'(size_reg) > OFS) || ((lane_raw & lane_mask) != '0);
`endif
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word        (rd_word),
    .wdata       (wdata_reg),
    .lane        (eff_lane),
    .size        (eff_size),
    .is_unsigned (uns_reg),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req_valid)      state_next = WAIT;
      WAIT:    if (cnt_reg == '0)  state_next = RESP;
      RESP:    if (resp_ready)     state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);

  // Capture, latency count and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= SZ_B;
      uns_reg    <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr[AW-1:0];
        wdata_reg <= req_wdata;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        cnt_reg   <= CNT_W'(LATENCY - 1);
      end else if (state_reg == WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (commit) begin
        resp_rdata <= (we_reg || fault) ? '0 : load_data;
        resp_err   <= fault;
      end
    end
  end

  // Storage write; a reset at the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst && commit && we_reg && !fault) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Reference model: little-endian byte array, 128 words of 4 bytes.
  logic [7:0] mbytes [512];

  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [1:0] size,
                                       input logic uns, output logic [31:0] rdata,
                                       output logic err);
    int n, lane, base, word;
    logic [31:0] v;
    word = int'((addr / 4) % 128);
    lane = int'(addr % 4);
    n    = 1 << size;
    err  = 1'b0;
    rdata = '0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (n > 4 || (addr % n) != 0) begin
      err = 1'b1;
      return;
    end
`else
    if (n > 4) n = 4;
    lane = lane - (lane % n);
`endif
    base = word * 4 + lane;
    if (we) begin
      for (int i = 0; i < n; i++) mbytes[base + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | ({24'b0, mbytes[base + i]} << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rdata = v;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request and wait for the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    @(posedge clk); #1;
    // Busy-period garbage: must be ignored outside IDLE.
    req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("ready_after_resp", req_ready, 1);
    check("valid_after_resp", resp_valid, 0);
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int hold,
                         output logic [31:0] rdata, output logic err);
    int lat;
    issue(we, addr, wdata, size, uns);
    wait_resp(lat);
    check("latency", lat, LATENCY);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
    end
    rdata = resp_rdata;
    err   = resp_err;
    handshake();
    txn++;
    $display("txn %0d we=%0d addr=0x%0h wdata=0x%0h size=%0d uns=%0d -> rdata=0x%0h err=%0d",
             txn, we, addr, wdata, size, uns, rdata, err);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;

    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 4; b++) mbytes[4*w + b] = (b == 0) ? 8'(w) : 8'h00;

    vecs[0]  = '{1'b0, 32'h10,  32'h0,         2'd2, 1'b0, 32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b1, 32'h21,  32'h0000_00AB, 2'd0, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h20,  32'h0,         2'd2, 1'b0, 32'h0000_AB08, 1'b0};
    vecs[3]  = '{1'b0, 32'h21,  32'h0,         2'd0, 1'b0, 32'hFFFF_FFAB, 1'b0};
    vecs[4]  = '{1'b0, 32'h21,  32'h0,         2'd0, 1'b1, 32'h0000_00AB, 1'b0};
    vecs[5]  = '{1'b0, 32'h20,  32'h0,         2'd1, 1'b1, 32'h0000_AB08, 1'b0};
    vecs[6]  = '{1'b0, 32'h20,  32'h0,         2'd1, 1'b0, 32'hFFFF_AB08, 1'b0};
    vecs[7]  = '{1'b0, 32'h200, 32'h0,         2'd2, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h30,  32'h1234_8765, 2'd1, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h30,  32'h0,         2'd2, 1'b0, 32'h0000_8765, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[10] = '{1'b0, 32'h6,   32'h0,         2'd2, 1'b0, 32'h0,         1'b1};
`else
    vecs[10] = '{1'b0, 32'h6,   32'h0,         2'd2, 1'b0, 32'h0000_0001, 1'b0};
`endif

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_resp_err", resp_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, 0, rd, er);
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
    end

    // Response held for 5 cycles: outputs stable, no new accept.
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    wait_resp(lat);
    check("hold_latency", lat, LATENCY);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, 32'h10);
      check("hold_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    handshake();
    txn++;
    $display("txn %0d held lw addr=0x40 -> rdata=0x10", txn);

    // Reset at the commit edge of a store drops the store.
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 2'd2, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", resp_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("commit_reset_valid", resp_valid, 0);
    check("commit_reset_ready", req_ready, 1);
    check("commit_reset_rdata", resp_rdata, 0);
    check("commit_reset_err", resp_err, 0);
    rst = 1'b1;
    txn++;
    $display("txn %0d sw addr=0x8 killed by reset", txn);
    run_req(1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("dropped_store_rdata", rd, 32'h2);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      logic        we, uns;
      logic [31:0] addr, wdata;
      logic [1:0]  size;
      we    = 1'($urandom);
      uns   = 1'($urandom);
      addr  = 32'($urandom_range(0, 32'h3FF));
      wdata = $urandom;
      size  = 2'($urandom_range(0, 3));
      run_req(we, addr, wdata, size, uns, $urandom_range(0, 3), rd, er);
      model_access(we, addr, wdata, size, uns, mrd, mer);
      check($sformatf("rand%0d_rdata", i), rd, mrd);
      check($sformatf("rand%0d_err", i), er, mer);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
